// File: rtl/power_accum_pkg.sv
// Shared constants and types for the frame-integrating power accumulator.
package power_accum_pkg;

    localparam int unsigned WORDS           = 2048;
    localparam int unsigned BEATS_PER_FRAME = 1025;
    localparam int unsigned LANES           = 4;
    localparam int unsigned DATA_WIDTH_DEF  = 53;
    localparam int unsigned ACC_WIDTH_DEF   = DATA_WIDTH_DEF + 2;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef logic [LANES-1:0][DATA_WIDTH_DEF-1:0] data_lanes_t;
    typedef logic [LANES-1:0][ACC_WIDTH_DEF-1:0]  acc_lanes_t;

endpackage

// File: rtl/acc_ram_1r1w.sv
// Simple dual-port RAM: one write port, one read port, registered read data.
module acc_ram_1r1w #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 220,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: commit on the clock edge.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port: one-cycle latency, output holds when no read is issued.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/power_frame_accum.sv
// Bin-wise integration of 2^LOG2_FRAMES power frames into even/odd word
// banks, followed by an in-order averaged drain over valid/ready.
module power_frame_accum #(
    parameter int unsigned DATA_WIDTH  = 53,
    parameter int unsigned LOG2_FRAMES = 2,
    parameter int unsigned ACC_WIDTH   = DATA_WIDTH + LOG2_FRAMES,
    parameter int unsigned WORDS       = 2048
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_ready,
    input  logic [4*DATA_WIDTH-1:0] col_1,
    input  logic [4*DATA_WIDTH-1:0] col_2,
    input  logic [10:0]             out_index_col1,
    input  logic [10:0]             out_index_col2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*DATA_WIDTH-1:0] out_data,
    output logic [10:0]             out_word,
    output logic                    out_last,
    output logic                    busy,
    output logic                    err_overrun,
    output logic                    err_short
);

    import power_accum_pkg::*;

    localparam int unsigned NFRAMES = 1 << LOG2_FRAMES;
    localparam int unsigned AW      = 10;

    typedef logic [3:0][ACC_WIDTH-1:0]  acc_t;
    typedef logic [3:0][DATA_WIDTH-1:0] dat_t;

    state_t       state;
    logic [10:0]  beat_cnt;
    logic [6:0]   frame_cnt;
    logic         resync;
    logic         accept, col2_live, last_beat, final_frame;

    logic         p1_v, p2_v, p_first;
    logic [10:0]  p1_idx, p2_idx;
    dat_t         p1_dat, p2_dat;
    acc_t         s1, s2, new1, new2;

    logic         ev_re, od_re, ev_we, od_we;
    logic [AW-1:0] ev_ra, od_ra, ev_wa, od_wa;
    acc_t         ev_rd, od_rd, ev_wd, od_wd;

    logic [10:0]  rd_word, rd_pend_word;
    logic         rd_done, rd_pend, rd_issue, pop;
    logic [2:0]   fill_next;
    acc_t         drn_raw;
    dat_t         drn_dat, sk_data;
    logic         drn_last;
    logic [10:0]  sk_word;
    logic         sk_last, sk_valid;

    function automatic acc_t rmw(input acc_t stored, input dat_t din, input logic first);
        acc_t r;
        for (int unsigned k = 0; k < 4; k++) begin
            if (first) r[k] = ACC_WIDTH'(din[k]);
            else       r[k] = stored[k] + ACC_WIDTH'(din[k]);
        end
        return r;
    endfunction

    // While a frame arrives mid-drain, keep ignoring it until in_ready falls,
    // so accumulation only ever starts on a frame boundary.
    assign accept      = in_ready && (state == ACCUM) && !resync;
    assign col2_live   = (beat_cnt >= 11'd2);
    assign last_beat   = accept && (beat_cnt == 11'(BEATS_PER_FRAME - 1));
    assign final_frame = (frame_cnt == 7'(NFRAMES - 1));
    assign busy        = (state == DRAIN) || (frame_cnt != 7'd0);
    assign pop         = out_valid && out_ready;

    // Drain reads may be issued only when the output stage can absorb them.
    assign fill_next = 3'(out_valid) + 3'(sk_valid) + 3'(rd_pend) - 3'(pop);
    assign rd_issue  = (state == DRAIN) && !rd_done && (fill_next <= 3'd1);

    // Bank read port steering: drain sequencer in DRAIN, beat columns in ACCUM.
    always_comb begin
        ev_re = 1'b0;
        od_re = 1'b0;
        ev_ra = '0;
        od_ra = '0;
        if (state == DRAIN) begin
            if (rd_issue) begin
                if (rd_word[0]) begin od_re = 1'b1; od_ra = rd_word[10:1]; end
                else            begin ev_re = 1'b1; ev_ra = rd_word[10:1]; end
            end
        end else if (accept) begin
            if (out_index_col1[0]) begin od_re = 1'b1; od_ra = out_index_col1[10:1]; end
            else                   begin ev_re = 1'b1; ev_ra = out_index_col1[10:1]; end
            if (col2_live) begin
                if (out_index_col2[0]) begin od_re = 1'b1; od_ra = out_index_col2[10:1]; end
                else                   begin ev_re = 1'b1; ev_ra = out_index_col2[10:1]; end
            end
        end
    end

    // Register beat data alongside the issued reads for the add stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_v    <= 1'b0;
            p2_v    <= 1'b0;
            p_first <= 1'b0;
            p1_idx  <= '0;
            p2_idx  <= '0;
            p1_dat  <= '0;
            p2_dat  <= '0;
        end else begin
            p1_v    <= accept;
            p2_v    <= accept && col2_live;
            p_first <= (frame_cnt == 7'd0);
            p1_idx  <= out_index_col1;
            p2_idx  <= out_index_col2;
            p1_dat  <= col_1;
            p2_dat  <= col_2;
        end
    end

    // Add stage: pick each column's bank result and form the new sums.
    always_comb begin
        s1   = p1_idx[0] ? od_rd : ev_rd;
        s2   = p2_idx[0] ? od_rd : ev_rd;
        new1 = rmw(s1, p1_dat, p_first);
        new2 = rmw(s2, p2_dat, p_first);
    end

    // Bank write port steering for the retiring beat.
    always_comb begin
        ev_we = 1'b0;
        od_we = 1'b0;
        ev_wa = '0;
        od_wa = '0;
        ev_wd = '0;
        od_wd = '0;
        if (p1_v) begin
            if (p1_idx[0]) begin od_we = 1'b1; od_wa = p1_idx[10:1]; od_wd = new1; end
            else           begin ev_we = 1'b1; ev_wa = p1_idx[10:1]; ev_wd = new1; end
        end
        if (p2_v) begin
            if (p2_idx[0]) begin od_we = 1'b1; od_wa = p2_idx[10:1]; od_wd = new2; end
            else           begin ev_we = 1'b1; ev_wa = p2_idx[10:1]; ev_wd = new2; end
        end
    end

    acc_ram_1r1w #(.DEPTH(1024), .WIDTH(4 * ACC_WIDTH), .AW(AW)) u_bank_even (
        .clk   (clk),
        .re    (ev_re),
        .raddr (ev_ra),
        .rdata (ev_rd),
        .we    (ev_we),
        .waddr (ev_wa),
        .wdata (ev_wd)
    );

    acc_ram_1r1w #(.DEPTH(1024), .WIDTH(4 * ACC_WIDTH), .AW(AW)) u_bank_odd (
        .clk   (clk),
        .re    (od_re),
        .raddr (od_ra),
        .rdata (od_rd),
        .we    (od_we),
        .waddr (od_wa),
        .wdata (od_wd)
    );

    // Frame/beat bookkeeping, state transitions and sticky error flags.
    // DRAIN is entered on the final beat itself; its last write still
    // retires on the next edge while the first drain read (word 0, a
    // different address) is issued in parallel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            beat_cnt    <= '0;
            frame_cnt   <= '0;
            resync      <= 1'b0;
            err_short   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (state == ACCUM) begin
                if (accept) begin
                    if (last_beat) begin
                        beat_cnt <= '0;
                        if (final_frame) begin
                            frame_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            frame_cnt <= frame_cnt + 7'd1;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + 11'd1;
                    end
                end else if (!in_ready && beat_cnt != 11'd0) begin
                    err_short <= 1'b1;
                    beat_cnt  <= '0;
                end
            end else begin
                if (in_ready) err_overrun <= 1'b1;
                if (pop && out_last) state <= ACCUM;
            end
            if (state == DRAIN && in_ready) resync <= 1'b1;
            else if (!in_ready)             resync <= 1'b0;
        end
    end

    // Drain read sequencer: issue words 0..WORDS-1 in order, track the one in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_word      <= '0;
            rd_done      <= 1'b0;
            rd_pend      <= 1'b0;
            rd_pend_word <= '0;
        end else if (state == ACCUM) begin
            rd_word <= '0;
            rd_done <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_issue;
            if (rd_issue) begin
                rd_pend_word <= rd_word;
                rd_word      <= rd_word + 11'd1;
                rd_done      <= (rd_word == 11'(WORDS - 1));
            end
        end
    end

    // Scale the returning accumulator word down to the frame average.
    always_comb begin
        drn_raw  = rd_pend_word[0] ? od_rd : ev_rd;
        drn_last = (rd_pend_word == 11'(WORDS - 1));
        for (int unsigned k = 0; k < 4; k++) begin
            drn_dat[k] = DATA_WIDTH'(drn_raw[k] >> LOG2_FRAMES);
        end
    end

    // Output register plus one-entry skid; output fields hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_word  <= '0;
            out_last  <= 1'b0;
            sk_valid  <= 1'b0;
            sk_data   <= '0;
            sk_word   <= '0;
            sk_last   <= 1'b0;
        end else if (!out_valid || pop) begin
            if (sk_valid) begin
                out_valid <= 1'b1;
                out_data  <= sk_data;
                out_word  <= sk_word;
                out_last  <= sk_last;
                sk_valid  <= rd_pend;
                sk_data   <= drn_dat;
                sk_word   <= rd_pend_word;
                sk_last   <= drn_last;
            end else begin
                out_valid <= rd_pend;
                if (rd_pend) begin
                    out_data <= drn_dat;
                    out_word <= rd_pend_word;
                    out_last <= drn_last;
                end
            end
        end else if (rd_pend) begin
            sk_valid <= 1'b1;
            sk_data  <= drn_dat;
            sk_word  <= rd_pend_word;
            sk_last  <= drn_last;
        end
    end

endmodule

// File: tb/tb_power_frame_accum.sv
// Self-checking bench for power_frame_accum: one instance integrating a single
// frame, one integrating four, both driven from a shared input stream.
module tb_power_frame_accum;

    localparam int DW   = 53;
    localparam int BINS = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_ready = 1'b0;
    logic out_ready = 1'b0;
    logic [4*DW-1:0] col_1 = '0, col_2 = '0;
    logic [10:0] idx1 = '0, idx2 = '0;

    logic v0, l0, b0, eo0, es0, v2, l2, b2, eo2, es2;
    logic [4*DW-1:0] d0, d2;
    logic [10:0] w0, w2;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0]   fv      [BINS];
    longint unsigned sum     [BINS];
    logic [DW-1:0]   exp_bin [BINS];

    power_frame_accum #(.DATA_WIDTH(DW), .LOG2_FRAMES(0)) u_l0 (
        .clk(clk), .rst_n(rst_n), .in_ready(in_ready), .col_1(col_1), .col_2(col_2),
        .out_index_col1(idx1), .out_index_col2(idx2), .out_valid(v0), .out_ready(out_ready),
        .out_data(d0), .out_word(w0), .out_last(l0), .busy(b0),
        .err_overrun(eo0), .err_short(es0));

    power_frame_accum #(.DATA_WIDTH(DW), .LOG2_FRAMES(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .in_ready(in_ready), .col_1(col_1), .col_2(col_2),
        .out_index_col1(idx1), .out_index_col2(idx2), .out_valid(v2), .out_ready(out_ready),
        .out_data(d2), .out_word(w2), .out_last(l2), .busy(b2),
        .err_overrun(eo2), .err_short(es2));

    // Free-running clock.
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd53();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[DW-1:0];
    endfunction

    function automatic logic [4*DW-1:0] rnd_word();
        logic [4*DW-1:0] r;
        r = '0;
        for (int k = 0; k < 7; k++) r = (r << 32) | (4*DW)'($urandom);
        return r;
    endfunction

    function automatic logic [4*DW-1:0] pack_in(input int w);
        logic [4*DW-1:0] r;
        for (int k = 0; k < 4; k++) r[k*DW +: DW] = fv[4*w + k];
        return r;
    endfunction

    function automatic logic [4*DW-1:0] pack_exp(input int w);
        logic [4*DW-1:0] r;
        for (int k = 0; k < 4; k++) r[k*DW +: DW] = exp_bin[4*w + k];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < BINS; i++) sum[i] = 0;
    endtask

    task automatic model_add();
        for (int i = 0; i < BINS; i++) sum[i] = sum[i] + longint'(fv[i]);
    endtask

    task automatic model_final(input int log2f);
        for (int i = 0; i < BINS; i++) exp_bin[i] = DW'(sum[i] >> log2f);
    endtask

    task automatic fill_const(input logic [DW-1:0] val);
        for (int i = 0; i < BINS; i++) fv[i] = val;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < BINS; i++) fv[i] = rnd53();
    endtask

    task automatic do_reset();
        in_ready  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Drive nbeats beats of the frame held in fv; col_2 carries junk on beats 0 and 1.
    task automatic send_frame(input int nbeats);
        int i1;
        for (int b = 0; b < nbeats; b++) begin
            i1 = (b < 2) ? b : 2 * (b - 1);
            in_ready = 1'b1;
            idx1  = i1[10:0];
            col_1 = pack_in(i1);
            if (b >= 2) begin
                idx2  = 11'(i1 + 1);
                col_2 = pack_in(i1 + 1);
            end else begin
                idx2  = 11'($urandom);
                col_2 = rnd_word();
            end
            tick();
        end
        in_ready = 1'b0;
    endtask

    // Collect one full drain from the selected instance, checking order, data,
    // out_last and hold-while-stalled; reports first-valid delay and span.
    task automatic drain(input bit sel, input bit rand_ready, input string tag,
                         output int first_lat, output int span);
        int n;
        int last_acc;
        bit stall;
        logic v, l, pl;
        logic [4*DW-1:0] d, pd;
        logic [10:0] w, pw;
        n = 0; first_lat = -1; last_acc = -1; stall = 0;
        pd = '0; pw = '0; pl = 1'b0;
        for (int cyc = 0; cyc < 9000 && n < 2048; cyc++) begin
            v = sel ? v2 : v0;
            d = sel ? d2 : d0;
            w = sel ? w2 : w0;
            l = sel ? l2 : l0;
            if (stall) begin
                tests++;
                if (v !== 1'b1 || d !== pd || w !== pw || l !== pl) begin
                    fails++;
                    if (fails < 20)
                        $display("FAIL %s stall_hold: valid=%b word=%0d last=%b, required valid=1 word=%0d last=%b (data %s)",
                                 tag, v, w, l, pw, pl, (d === pd) ? "held" : "changed");
                end
            end
            out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (v === 1'b1 && first_lat < 0) first_lat = cyc;
            if (v === 1'b1 && out_ready) begin
                tests++;
                if (w !== n[10:0] || d !== pack_exp(n) || l !== (n == 2047)) begin
                    fails++;
                    if (fails < 20)
                        $display("FAIL %s drain_word: got word=%0d last=%b data=%h, required word=%0d last=%b data=%h",
                                 tag, w, l, d, n, (n == 2047), pack_exp(n));
                end
                n++;
                last_acc = cyc;
            end
            stall = (v === 1'b1) && !out_ready;
            pd = d; pw = w; pl = l;
            tick();
        end
        out_ready = 1'b0;
        tests++;
        if (n != 2048) begin
            fails++;
            $display("FAIL %s drain_count: got %0d words, required 2048", tag, n);
        end
        span = last_acc - first_lat;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({v0, l0, b0, eo0, es0, w0} !== '0 || d0 !== '0) begin
            fails++;
            $display("FAIL reset_l0: got valid=%b last=%b busy=%b eo=%b es=%b word=%0d, required all 0",
                     v0, l0, b0, eo0, es0, w0);
        end
        tests++;
        if ({v2, l2, b2, eo2, es2, w2} !== '0 || d2 !== '0) begin
            fails++;
            $display("FAIL reset_l2: got valid=%b last=%b busy=%b eo=%b es=%b word=%0d, required all 0",
                     v2, l2, b2, eo2, es2, w2);
        end
    endtask

    task automatic test_single_frame();
        int fl, sp;
        do_reset();
        for (int i = 0; i < BINS; i++) fv[i] = DW'(i);
        model_clear(); model_add(); model_final(0);
        send_frame(1025);
        drain(1'b0, 1'b0, "l0_single", fl, sp);
        tests++;
        if (fl != 2) begin
            fails++;
            $display("FAIL l0_first_valid: got %0d edges after last beat, required 2", fl);
        end
        tests++;
        if (sp != 2047) begin
            fails++;
            $display("FAIL l0_throughput: got span %0d cycles, required 2047", sp);
        end
        tests++;
        if (b0 !== 1'b0 || v0 !== 1'b0 || eo0 !== 1'b0 || es0 !== 1'b0) begin
            fails++;
            $display("FAIL l0_after_drain: got busy=%b valid=%b eo=%b es=%b, required 0 0 0 0", b0, v0, eo0, es0);
        end
    endtask

    task automatic test_back_to_back();
        int fl, sp;
        logic [DW-1:0] vals [4];
        vals[0] = 1; vals[1] = 2; vals[2] = 3; vals[3] = 6;
        do_reset();
        model_clear();
        tests++;
        if (b2 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_busy_idle: got %b, required 0", b2);
        end
        for (int f = 0; f < 4; f++) begin
            fill_const(vals[f]);
            model_add();
            send_frame(1025);
            if (f == 0) begin
                tests++;
                if (b2 !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_busy_accum: got %b, required 1", b2);
                end
            end
        end
        model_final(2);
        drain(1'b1, 1'b0, "l2_b2b", fl, sp);
        tests++;
        if (fl != 2 || sp != 2047) begin
            fails++;
            $display("FAIL b2b_timing: got first=%0d span=%0d, required 2 and 2047", fl, sp);
        end
        tests++;
        if (b2 !== 1'b0 || v2 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_busy_end: got busy=%b valid=%b, required 0 0", b2, v2);
        end
    endtask

    task automatic test_max_values();
        int fl, sp;
        do_reset();
        model_clear();
        fill_const('1);
        for (int f = 0; f < 4; f++) begin
            model_add();
            send_frame(1025);
        end
        model_final(2);
        drain(1'b1, 1'b0, "l2_max", fl, sp);
    endtask

    task automatic test_random_ready();
        int fl, sp;
        do_reset();
        model_clear();
        for (int f = 0; f < 4; f++) begin
            fill_rand();
            model_add();
            send_frame(1025);
        end
        model_final(2);
        drain(1'b1, 1'b1, "l2_rand_ready", fl, sp);
    endtask

    task automatic test_overrun();
        int fl, sp;
        model_clear();
        for (int f = 0; f < 4; f++) begin
            fill_rand();
            model_add();
            send_frame(1025);
        end
        model_final(2);
        fill_rand();
        fork
            begin
                repeat (20) tick();
                send_frame(1025);
            end
            drain(1'b1, 1'b0, "l2_overrun", fl, sp);
        join
        tests++;
        if (eo2 !== 1'b1 || es2 !== 1'b0) begin
            fails++;
            $display("FAIL overrun_flags: got eo=%b es=%b, required 1 0", eo2, es2);
        end
        repeat (5) tick();
        model_clear();
        for (int f = 0; f < 4; f++) begin
            fill_rand();
            model_add();
            send_frame(1025);
        end
        model_final(2);
        drain(1'b1, 1'b0, "l2_after_overrun", fl, sp);
        tests++;
        if (eo2 !== 1'b1) begin
            fails++;
            $display("FAIL overrun_sticky: got %b, required 1", eo2);
        end
    endtask

    task automatic test_short_frame();
        int fl, sp;
        do_reset();
        fill_rand();
        send_frame(500);
        repeat (3) tick();
        tests++;
        if (es2 !== 1'b1 || b2 !== 1'b0) begin
            fails++;
            $display("FAIL short_flag: got es=%b busy=%b, required es=1 busy=0", es2, b2);
        end
        model_clear();
        for (int f = 0; f < 4; f++) begin
            fill_rand();
            model_add();
            send_frame(1025);
        end
        model_final(2);
        drain(1'b1, 1'b0, "l2_after_short", fl, sp);
        tests++;
        if (es2 !== 1'b1 || eo2 !== 1'b0) begin
            fails++;
            $display("FAIL short_sticky: got es=%b eo=%b, required 1 0", es2, eo2);
        end
    endtask

    task automatic test_reset_mid();
        int fl, sp;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            fill_rand();
            send_frame(1025);
        end
        fill_rand();
        send_frame(300);
        rst_n = 1'b0;
        #1;
        tests++;
        if (b2 !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_busy: got %b, required 0 before any clock edge", b2);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (es2 !== 1'b0 || eo2 !== 1'b0 || b2 !== 1'b0 || v2 !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_state: got es=%b eo=%b busy=%b valid=%b, required 0 0 0 0", es2, eo2, b2, v2);
        end
        model_clear();
        for (int f = 0; f < 4; f++) begin
            fill_rand();
            model_add();
            send_frame(1025);
        end
        model_final(2);
        drain(1'b1, 1'b0, "l2_after_reset", fl, sp);
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_max_values();
        test_random_ready();
        test_overrun();
        test_short_frame();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
